// File: rtl/player_motion.sv
// Per-player position/heading controller. Once per video frame it samples the
// direction keys, builds a clamped candidate position, asks the map ROM whether
// the destination tile is walkable and commits the move only if it is.
module player_motion #(
  parameter int unsigned START_X = 1600,
  parameter int unsigned START_Y = 1200,
  parameter int unsigned STEP    = 4,
  parameter int unsigned X_MIN   = 69,
  parameter int unsigned X_MAX   = 3130,
  parameter int unsigned Y_MIN   = 69,
  parameter int unsigned Y_MAX   = 2330,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  output logic        tile_req,
  output logic [12:0] tile_addr,
  input  logic        tile_valid,
  input  logic [1:0]  tile_data,
  output logic [11:0] pos_x,
  output logic [11:0] pos_y,
  output logic [1:0]  dir,
  output logic        moved,
  output logic        busy
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StCalc   = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;
  localparam logic [1:0] StCommit = 2'd3;

  localparam logic [1:0] DirN = 2'b00;
  localparam logic [1:0] DirS = 2'b01;
  localparam logic [1:0] DirE = 2'b10;
  localparam logic [1:0] DirW = 2'b11;

  localparam logic [11:0] StepW  = 12'(STEP);
  localparam logic [11:0] XMinW  = 12'(X_MIN);
  localparam logic [11:0] XMaxW  = 12'(X_MAX);
  localparam logic [11:0] YMinW  = 12'(Y_MIN);
  localparam logic [11:0] YMaxW  = 12'(Y_MAX);
  localparam logic [11:0] StartX = 12'(START_X);
  localparam logic [11:0] StartY = 12'(START_Y);

  // Counter runs 0..TIMEOUT-1 while waiting for the ROM.
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [1:0]      state_q, state_d;
  logic            frame_q;
  logic            frame_edge;
  logic [3:0]      keys_q, keys_d;       // {up, down, left, right}
  logic [11:0]     pos_x_q, pos_x_d;
  logic [11:0]     pos_y_q, pos_y_d;
  logic [11:0]     cand_x_q, cand_x_d;
  logic [11:0]     cand_y_q, cand_y_d;
  logic [1:0]      dir_q, dir_d;
  logic [12:0]     addr_q, addr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      tile_q, tile_d;
  logic            moved_q, moved_d;

  logic [11:0]     cand_x, cand_y;
  logic [1:0]      dir_sel;
  logic            have_key;
  logic            go;
  logic [12:0]     addr_calc;

  // Decrement with floor at lo; compares before subtracting so it cannot wrap.
  function automatic logic [11:0] step_dn(input logic [11:0] v, input logic [11:0] lo,
                                          input logic [11:0] hi);
    logic [11:0] r;
    r = (v < lo + StepW) ? lo : v - StepW;
    if (r > hi) r = hi;
    return r;
  endfunction

  // Increment in 13 bits so the ceiling compare sees any carry.
  function automatic logic [11:0] step_up(input logic [11:0] v, input logic [11:0] lo,
                                          input logic [11:0] hi);
    logic [12:0] s;
    s = {1'b0, v} + {1'b0, StepW};
    if (s > {1'b0, hi}) return hi;
    else if (s[11:0] < lo) return lo;
    else return s[11:0];
  endfunction

  assign frame_edge = frame_clk & ~frame_q;

  // Candidate position and heading from the latched keys (up > down > left > right).
  always_comb begin
    cand_x   = pos_x_q;
    cand_y   = pos_y_q;
    dir_sel  = dir_q;
    have_key = 1'b1;
    if (keys_q[3]) begin
      cand_y  = step_dn(pos_y_q, YMinW, YMaxW);
      dir_sel = DirN;
    end else if (keys_q[2]) begin
      cand_y  = step_up(pos_y_q, YMinW, YMaxW);
      dir_sel = DirS;
    end else if (keys_q[1]) begin
      cand_x  = step_dn(pos_x_q, XMinW, XMaxW);
      dir_sel = DirW;
    end else if (keys_q[0]) begin
      cand_x  = step_up(pos_x_q, XMinW, XMaxW);
      dir_sel = DirE;
    end else begin
      have_key = 1'b0;
    end
    addr_calc = {6'd0, cand_y[11:5]} * 13'd100 + {6'd0, cand_x[11:5]};
    go = (state_q == StCalc) && have_key && ((cand_x != pos_x_q) || (cand_y != pos_y_q));
  end

  // Next-state logic for the frame/lookup/commit sequence.
  always_comb begin
    state_d  = state_q;
    keys_d   = keys_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    cand_x_d = cand_x_q;
    cand_y_d = cand_y_q;
    dir_d    = dir_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    tile_d   = tile_q;
    moved_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_edge) begin
          keys_d  = {key_up, key_down, key_left, key_right};
          state_d = StCalc;
        end
      end
      StCalc: begin
        // Heading follows the key even when the move ends up blocked.
        if (have_key) dir_d = dir_sel;
        if (go) begin
          cand_x_d = cand_x;
          cand_y_d = cand_y;
          addr_d   = addr_calc;
          cnt_d    = '0;
          state_d  = StWait;
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (tile_valid) begin
          tile_d  = tile_data;
          state_d = StCommit;
        end else if (cnt_q == CntLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCommit: begin
        // Grass (01) and sand (11) are walkable; bit 0 captures exactly that.
        if (tile_q[0]) begin
          pos_x_d = cand_x_q;
          pos_y_d = cand_y_q;
          moved_d = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset abandons any lookup in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= StIdle;
      frame_q  <= 1'b0;
      keys_q   <= 4'd0;
      pos_x_q  <= StartX;
      pos_y_q  <= StartY;
      cand_x_q <= StartX;
      cand_y_q <= StartY;
      dir_q    <= DirS;
      addr_q   <= 13'd0;
      cnt_q    <= '0;
      tile_q   <= 2'b00;
      moved_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_clk;
      keys_q   <= keys_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      cand_x_q <= cand_x_d;
      cand_y_q <= cand_y_d;
      dir_q    <= dir_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      tile_q   <= tile_d;
      moved_q  <= moved_d;
    end
  end

  // Address is live from the candidate during the request cycle, then held.
  assign tile_req  = go;
  assign tile_addr = (state_q == StCalc) ? addr_calc : addr_q;
  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign dir       = dir_q;
  assign moved     = moved_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: doc/player_motion.md
Name: player_motion

Overview:
- Per-player position/heading controller that sits directly upstream of the map/sprite renderer.
- Produces the 12-bit absolute map coordinates and the 2-bit facing direction that the renderer consumes as xOne/yOne/p1dir (or xTwo/yTwo/p2dir). One instance per player.
- Once per video frame it samples the directional keys, computes a candidate position, and checks the destination tile in the map-layout ROM over a request/valid handshake. It commits the move only if the tile is walkable.

Parameters:
- START_X, 1600, reset x coordinate (map pixels)
- START_Y, 1200, reset y coordinate
- STEP, 4, pixels moved per frame
- X_MIN, 69, minimum legal x (sprite centre; left wall 32 + sprite half-width 37)
- X_MAX, 3130, maximum legal x (3168 − 38)
- Y_MIN, 69, minimum legal y
- Y_MAX, 2330, maximum legal y (2368 − 38)
- TIMEOUT, 15, max cycles to wait for tile_valid

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- frame_clk  in  1  vertical sync from VGA controller, synchronous to Clk
- key_up  in  1  held up key
- key_down  in  1  held down key
- key_left  in  1  held left key
- key_right  in  1  held right key
- tile_req  out  1  one-cycle map-lookup request
- tile_addr  out  13  map index = (y>>5)*100 + (x>>5)
- tile_valid  in  1  lookup response strobe
- tile_data  in  2  tile code: 00 void, 01 grass, 10 water, 11 sand
- pos_x  out  12  committed x
- pos_y  out  12  committed y
- dir  out  2  facing: 00 N, 01 S, 10 E, 11 W
- moved  out  1  one-cycle pulse when pos_x/pos_y change
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (asynchronous, immediate):
  - pos_x=START_X, pos_y=START_Y, dir=01.
  - tile_req=0, tile_addr=0, moved=0, busy=0.
  - State=IDLE, frame_q=0.
- Frame edge detection:
  - frame_q registers frame_clk every cycle.
  - frame_edge = frame_clk & ~frame_q (rising edge).
- States: IDLE, CALC, WAIT, COMMIT.
- IDLE:
  - On frame_edge, latch the four keys and go to CALC.
  - An edge arriving in any other state is dropped.
- CALC (1 cycle):
  - Key priority is up > down > left > right; only one axis moves per frame.
  - Selected key sets dir in this cycle (N/S/E/W) even if the move is later blocked.
  - Candidate = current ± STEP on the selected axis (up = −y, left = −x), clamped to [MIN, MAX].
  - Subtraction must not underflow: when current < MIN+STEP, result is MIN.
  - No key pressed: dir unchanged → IDLE.
  - Clamped candidate equals current: → IDLE, no request.
  - Otherwise drive tile_addr from the candidate, pulse tile_req for exactly this one cycle, go to WAIT with wait counter = 0.
- WAIT:
  - tile_addr is held stable.
  - tile_valid=1 → sample tile_data, go to COMMIT.
  - Else increment the counter; at TIMEOUT go to IDLE with the move rejected.
  - tile_valid outside WAIT is ignored.
- COMMIT (1 cycle):
  - tile_data 01 or 11: pos_x/pos_y ← candidate on the clock edge ending COMMIT; moved=1 for the following cycle only.
  - tile_data 00 or 10: position unchanged, moved stays 0.
  - → IDLE.
- Latency:
  - A frame edge sampled at cycle n gives the CALC request at n+1.
  - With valid arriving k cycles after the request, the position updates at n+2+k.
- pos_x, pos_y and dir are registered and never glitch mid-frame.
- Reset asserted in WAIT/COMMIT aborts the lookup; no move is committed.

Test Plan:
- Reset, key_right held, one frame_clk edge, responder returns 01 after 2 cycles → tile_req once with tile_addr=(1200>>5)*100+(1604>>5)=3750; pos_x=1604, dir=10, moved pulses once.
- key_up held, responder returns 10 (water) → no pos change, dir=00, moved=0, busy returns low.
- pos_x=71, key_left → candidate clamped to 69, lookup issued. Repeat frame → candidate equals 69, no tile_req, dir=11.
- key_up+key_right together → only y decreases by 4, dir=00. No keys → no tile_req, dir held.
- Responder never asserts tile_valid → after 15 wait cycles busy=0, position unchanged. A second frame edge during WAIT is dropped (exactly one tile_req total).
- Assert Reset during WAIT, then respond with 01 → outputs immediately return to 1600/1200/01, no move committed, moved=0.
